// File: rtl/adder_pkg.sv
// adder_pkg
// Shared definitions for the pipelined adder/subtractor and its users.
//   op_e                 : operation select encoding carried on the `op` port
//   ADDER_WIDTH_DEFAULT  : default operand/result width
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int ADDER_WIDTH_DEFAULT = 16;

endpackage

// File: rtl/carry_lookahead.sv
// carry_lookahead
// Ripple-style carry network: resolves per-bit carry-in from generate and
// propagate vectors.
//   g   in  WIDTH  per-bit generate
//   p   in  WIDTH  per-bit propagate
//   cin in  1      carry into bit 0
//   c   out WIDTH  c[i] = carry into bit i
module carry_lookahead #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] p,
  input  logic             cin,
  output logic [WIDTH-1:0] c
);

  // The MSB generate/propagate only feed the carry out, which the caller
  // forms itself from c[WIDTH-1].
  logic unused_msb;
  assign unused_msb = &{1'b0, g[WIDTH-1], p[WIDTH-1]};

  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      c[i] = g[i-1] | (p[i-1] & c[i-1]);
    end
  end

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder
// Two-stage WIDTH-bit adder/subtractor with valid/ready on both sides.
// Stage 1 registers generate/propagate/carry-in; stage 2 resolves carries
// and holds sum/cout/ovf until the consumer accepts.
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   operand handshake
//   a, b, cin, op       operands; op 0 = a+b+cin, 1 = a-b (cin ignored)
//   out_valid/out_ready result handshake
//   sum, cout, ovf      result, carry out (SUB: 1 = no borrow), signed overflow
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic             v1;
  logic [WIDTH-1:0] g1;
  logic [WIDTH-1:0] p1;
  logic             c01;
  logic             v2;

  logic             ready2;
  logic             take_in;
  logic             advance;
  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] sum_n;
  logic             cout_n;
  logic             ovf_n;

  assign ready2   = !v2 || out_ready;
  assign in_ready = !v1 || ready2;
  assign take_in  = in_valid && in_ready;
  assign advance  = v1 && ready2;
  assign out_valid = v2;

  // Subtraction is a + ~b + 1: invert b here, force carry-in in stage 1.
  always_comb begin
    bx = b;
    if (op == OP_SUB) begin
      bx = ~b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1  <= 1'b0;
      g1  <= '0;
      p1  <= '0;
      c01 <= 1'b0;
    end else begin
      if (take_in) begin
        v1  <= 1'b1;
        g1  <= a & bx;
        p1  <= a ^ bx;
        c01 <= (op == OP_SUB) ? 1'b1 : cin;
      end else if (advance) begin
        v1 <= 1'b0;
      end
    end
  end

  carry_lookahead #(
    .WIDTH(WIDTH)
  ) u_cla (
    .g  (g1),
    .p  (p1),
    .cin(c01),
    .c  (c)
  );

  always_comb begin
    cout_n = g1[WIDTH-1] | (p1[WIDTH-1] & c[WIDTH-1]);
    sum_n  = p1 ^ c;
    ovf_n  = c[WIDTH-1] ^ cout_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2   <= 1'b0;
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      if (advance) begin
        v2   <= 1'b1;
        sum  <= sum_n;
        cout <= cout_n;
        ovf  <= ovf_n;
      end else if (v2 && out_ready) begin
        v2 <= 1'b0;
      end
    end
  end

endmodule
